eth_stats_poller: RTL and testbench
===================================

# eth_stats_poller

AXI4-Lite master that snapshots and reads out the register block of one Ethernet statistics collector, the initiator end of the collector's S_AXI slave port. On a trigger pulse or periodic timeout it writes a latch command to the collector's control register, then reads `num_regs` consecutive words. It emits the words as one AXI-Stream packet toward the DMA/FIFO path, so statistics are streamed without PS polling.

## Interface
- `axi_width`, 32, AXI data width and stream width; 32 or 64.
- `num_regs`, 8, words read per snapshot; 1..16.
- `base_addr`, 12'h010, address of the first word read; word stride is `axi_width/8`.
- `ctrl_addr`, 12'h000, control register address written before reading.
- `ctrl_value`, 1, value written to `ctrl_addr` to latch counters.
- `period`, 0, clk cycles between automatic snapshots; 0 disables the timer and leaves `trigger` only.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `trigger` in 1: one-cycle start request.
- `busy` out 1: high from snapshot start until the last beat is accepted or the snapshot aborts.
- `missed_count` out 16: saturating count of starts ignored while busy.
- `err_count` out 16: saturating count of non-OKAY responses.
- `m_axi_awaddr` out 12 / `m_axi_awprot` out 3 (always 0) / `m_axi_awvalid` out 1 / `m_axi_awready` in 1.
- `m_axi_wdata` out axi_width / `m_axi_wstrb` out axi_width/8 (all ones) / `m_axi_wvalid` out 1 / `m_axi_wready` in 1.
- `m_axi_bresp` in 2 / `m_axi_bvalid` in 1 / `m_axi_bready` out 1.
- `m_axi_araddr` out 12 / `m_axi_arprot` out 3 (always 0) / `m_axi_arvalid` out 1 / `m_axi_arready` in 1.
- `m_axi_rdata` in axi_width / `m_axi_rresp` in 2 / `m_axi_rvalid` in 1 / `m_axi_rready` out 1.
- `m_axis_tdata` out axi_width / `m_axis_tuser` out 1 / `m_axis_tlast` out 1 / `m_axis_tvalid` out 1 / `m_axis_tready` in 1.

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WB (await B), RA (AR outstanding), RD (await R), OUT (stream beat pending).
- IDLE→WR on start, where start = `trigger` OR timer expiry. awaddr=`ctrl_addr` and wdata=`ctrl_value`.
- WR: awvalid and wvalid rise together. Each drops on its own handshake, independently. Go to WB once both handshakes are done.
- WB: bready=1. On bvalid with OKAY, go to RA with index i=0. On non-OKAY, increment err_count, abort to IDLE, and emit no stream beats.
- RA: araddr = base_addr + i·(axi_width/8), truncated to 12 bits. Hold arvalid until arready, then go to RD.
- RD: rready=1. On rvalid, capture rdata into tdata. Set tuser = (rresp≠0) and increment err_count if non-OKAY. Set tlast = (i==num_regs−1). Go to OUT.
- OUT: hold tvalid with stable tdata/tuser/tlast until tready. On accept: if tlast, go to IDLE; else i+1 and go to RA.
- Only one AXI transaction is outstanding at any time; AR and W channels are never concurrent.
- Timer: counts clk cycles 0..period−1 continuously (when period>0) and expires on wrap.
- A start arriving while not IDLE (including simultaneous trigger and expiry while busy) increments missed_count by 1 per cycle. Trigger and expiry in the same IDLE cycle is one start and no miss.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: all valid and ready outputs 0, addresses and data 0, tuser/tlast 0, busy 0, counters 0, timer 0, FSM IDLE.
- Reset mid-operation returns to IDLE on the next edge and abandons any outstanding transaction. Resetting the slave at the same time is the integrator's job.
- Start at cycle 0 → awvalid/wvalid/busy high at cycle 1.
- B handshake at cycle n → arvalid at n+1.
- R handshake at n → tvalid at n+1.
- Stream accept at n → next arvalid at n+1, or busy low at n+1 after the last beat.
- Best case with zero-wait slave and sink: 2 + 3·num_regs cycles from WR entry to final accept.
- `valid` never depends combinationally on `ready`. The address/data on each channel stay stable while valid is high.

## Test plan
- Defaults, zero-wait slave returning rdata = address: trigger → AW 0x000 / W 1, then reads 0x010..0x02C. Stream has 8 beats 0x10..0x2C, tlast on beat 8 only, busy for 26 cycles.
- Slave with awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle and awvalid holds 4 cycles. Exactly one B, then the read phase proceeds.
- bresp=SLVERR: no AR issued, no stream beats, err_count=1, busy low the cycle after B.
- rresp=SLVERR on word 3 only: beat 3 has tuser=1, all other beats tuser=0, err_count=1, packet complete with 8 beats.
- tready low for 10 cycles on beat 2: tdata stable, no AR issued meanwhile. Three triggers during the snapshot → missed_count=3.
- period=100 with a slow sink so one snapshot spans an expiry → missed_count=1. Assert rst mid-read → all valids 0 next cycle, busy 0, counters 0.

Source files
------------

// File: rtl/eth_stats_poller.sv
// AXI4-Lite master that latches one statistics collector and streams
// num_regs consecutive register words out as a single AXI-Stream packet.
module eth_stats_poller #(
  parameter int          axi_width  = 32,
  parameter int          num_regs   = 8,
  parameter logic [11:0] base_addr  = 12'h010,
  parameter logic [11:0] ctrl_addr  = 12'h000,
  parameter logic [63:0] ctrl_value = 64'd1,
  parameter int          period     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  output logic                   busy,
  output logic [15:0]            missed_count,
  output logic [15:0]            err_count,

  output logic [11:0]            m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,

  output logic [axi_width-1:0]   m_axi_wdata,
  output logic [axi_width/8-1:0] m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,

  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,

  output logic [11:0]            m_axi_araddr,
  output logic [2:0]             m_axi_arprot,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,

  input  logic [axi_width-1:0]   m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,

  output logic [axi_width-1:0]   m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] WB   = 3'd2;
  localparam logic [2:0] RA   = 3'd3;
  localparam logic [2:0] RD   = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  localparam logic [31:0] STRIDE = 32'(axi_width / 8);
  localparam logic [4:0]  LAST   = 5'(num_regs - 1);
  localparam logic [31:0] TLIM   = (period > 0) ? 32'(period - 1) : 32'd0;

  logic [2:0]           r_state;
  logic [4:0]           r_idx;
  logic [31:0]          r_timer;
  logic [15:0]          r_missed;
  logic [15:0]          r_err;
  logic [11:0]          r_awaddr;
  logic                 r_awvalid;
  logic [axi_width-1:0] r_wdata;
  logic                 r_wvalid;
  logic [11:0]          r_araddr;
  logic                 r_arvalid;
  logic [axi_width-1:0] r_tdata;
  logic                 r_tuser;
  logic                 r_tlast;
  logic                 r_tvalid;

  logic w_expire;
  logic w_start;
  logic w_aw_done;
  logic w_w_done;
  logic w_b_err;
  logic w_r_err;
  logic w_err_inc;

  function automatic logic [11:0] f_addr(input logic [4:0] idx);
    logic [31:0] a;
    a = {20'd0, base_addr} + ({27'd0, idx} * STRIDE);
    return a[11:0];
  endfunction

  assign w_expire  = (period != 0) && (r_timer == TLIM);
  assign w_start   = trigger | w_expire;
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid || m_axi_wready;
  assign w_b_err   = (r_state == WB) && m_axi_bvalid
                     && (m_axi_bresp != 2'b00);
  assign w_r_err   = (r_state == RD) && m_axi_rvalid
                     && (m_axi_rresp != 2'b00);
  assign w_err_inc = w_b_err | w_r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (period != 0) begin
      r_timer <= w_expire ? 32'd0 : r_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_missed <= '0;
      r_err    <= '0;
    end else begin
      if (w_start && (r_state != IDLE) && (r_missed != 16'hFFFF))
        r_missed <= r_missed + 16'd1;
      if (w_err_inc && (r_err != 16'hFFFF))
        r_err <= r_err + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= 1'b0;
      r_tlast   <= 1'b0;
      r_tvalid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= WR;
            r_awaddr  <= ctrl_addr;
            r_wdata   <= ctrl_value[axi_width-1:0];
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        WR: begin
          // AW and W retire independently; B is awaited only after both
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= WB;
        end
        WB: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp == 2'b00) begin
              r_state   <= RA;
              r_idx     <= '0;
              r_araddr  <= f_addr(5'd0);
              r_arvalid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        RA: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RD;
          end
        end
        RD: begin
          if (m_axi_rvalid) begin
            r_tdata  <= m_axi_rdata;
            r_tuser  <= (m_axi_rresp != 2'b00);
            r_tlast  <= (r_idx == LAST);
            r_tvalid <= 1'b1;
            r_state  <= OUT;
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            r_tvalid <= 1'b0;
            if (r_tlast) begin
              r_state <= IDLE;
            end else begin
              r_idx     <= r_idx + 5'd1;
              r_araddr  <= f_addr(r_idx + 5'd1);
              r_arvalid <= 1'b1;
              r_state   <= RA;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign missed_count  = r_missed;
  assign err_count     = r_err;

  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = (r_state == WB);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = (r_state == RD);

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_eth_stats_poller.sv
// Bench for eth_stats_poller: AXI-Lite slave models, stalling sink,
// scoreboard queues and a negedge monitor that does all comparisons.
module tb_eth_stats_poller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  always #5 clk = ~clk;

  logic        busy;
  logic [15:0] missed_count, err_count;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata, tdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic        tuser, tlast, tvalid, tready;

  logic        busy_b;
  logic [15:0] missed_b, err_b;
  logic [11:0] awaddr_b, araddr_b;
  logic [2:0]  awprot_b, arprot_b;
  logic        awvalid_b, wvalid_b, bvalid_b, bready_b;
  logic        arvalid_b, rvalid_b, rready_b;
  logic [31:0] wdata_b, tdata_b;
  logic [3:0]  wstrb_b;
  logic        tuser_b, tlast_b, tvalid_b;
  logic        tready_b = 1'b1;

  eth_stats_poller u_dut (
    .clk(clk), .rst(rst), .trigger(trigger), .busy(busy),
    .missed_count(missed_count), .err_count(err_count),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  eth_stats_poller #(.period(100)) u_dut_t (
    .clk(clk), .rst(rst), .trigger(1'b0), .busy(busy_b),
    .missed_count(missed_b), .err_count(err_b),
    .m_axi_awaddr(awaddr_b), .m_axi_awprot(awprot_b),
    .m_axi_awvalid(awvalid_b), .m_axi_awready(1'b1),
    .m_axi_wdata(wdata_b), .m_axi_wstrb(wstrb_b),
    .m_axi_wvalid(wvalid_b), .m_axi_wready(1'b1),
    .m_axi_bresp(2'b00), .m_axi_bvalid(bvalid_b), .m_axi_bready(bready_b),
    .m_axi_araddr(araddr_b), .m_axi_arprot(arprot_b),
    .m_axi_arvalid(arvalid_b), .m_axi_arready(1'b1),
    .m_axi_rdata(32'h0), .m_axi_rresp(2'b00),
    .m_axi_rvalid(rvalid_b), .m_axi_rready(rready_b),
    .m_axis_tdata(tdata_b), .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b),
    .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b)
  );

  // Slave knobs, written only by the stimulus process
  int       aw_delay  = 0;
  logic [1:0] cfg_bresp = 2'b00;
  int       rerr_idx  = -1;
  int       stall_beat = 0;
  int       stall_len  = 0;

  int   aw_wait, rd_idx, beat_i, stall_n;
  logic aw_seen, w_seen;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign tready  = !((beat_i == stall_beat) && (stall_n < stall_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
      rd_idx <= 0; beat_i <= 0; stall_n <= 0;
    end else begin
      aw_wait <= (!awvalid || awready) ? 0 : aw_wait + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_seen || (awvalid && awready)) &&
          (w_seen || (wvalid && wready))) begin
        bvalid <= 1'b1; bresp <= cfg_bresp;
        aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen | (awvalid && awready);
        w_seen  <= w_seen | (wvalid && wready);
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= {20'd0, araddr};
        rresp  <= (rd_idx == rerr_idx) ? 2'b10 : 2'b00;
        rd_idx <= rd_idx + 1;
      end
      if (bvalid && bready) begin
        rd_idx <= 0; beat_i <= 0; stall_n <= 0;
      end else begin
        if (tvalid && tready)  beat_i  <= beat_i + 1;
        if (tvalid && !tready) stall_n <= stall_n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_b <= 1'b0; rvalid_b <= 1'b0;
    end else begin
      if (awvalid_b) bvalid_b <= 1'b1;
      else if (bready_b) bvalid_b <= 1'b0;
      if (arvalid_b) rvalid_b <= 1'b1;
      else if (rready_b) rvalid_b <= 1'b0;
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [7:0]  k;
    logic [31:0] e;
  } probe_t;

  localparam int P_BUSY = 0, P_AWV = 1, P_WV = 2, P_ARV = 3, P_TV = 4;
  localparam int P_BRDY = 5, P_RRDY = 6, P_MISS = 7, P_ERR = 8;
  localparam int P_AWADDR = 9, P_TDATA = 10, P_TUSER = 11, P_TLAST = 12;
  localparam int P_BUSYCYC = 13, P_AWCYC = 14, P_WCYC = 15, P_ARCNT = 16;
  localparam int P_BCNT = 17, P_BEATS = 18, P_MISSB = 19, P_BUSYB = 20;

  beat_t      exp_q[$];
  logic [11:0] exp_ar[$];
  logic [11:0] exp_aw[$];
  probe_t     probe_q[$];

  int vectors = 0;
  int miscompares = 0;
  int busy_cyc, awv_cyc, wv_cyc, ar_cnt, b_cnt, beats;
  logic        prev_stall;
  logic [33:0] prev_t;

  function automatic logic [31:0] pv(input int k);
    case (k)
      P_BUSY:    pv = {31'd0, busy};
      P_AWV:     pv = {31'd0, awvalid};
      P_WV:      pv = {31'd0, wvalid};
      P_ARV:     pv = {31'd0, arvalid};
      P_TV:      pv = {31'd0, tvalid};
      P_BRDY:    pv = {31'd0, bready};
      P_RRDY:    pv = {31'd0, rready};
      P_MISS:    pv = {16'd0, missed_count};
      P_ERR:     pv = {16'd0, err_count};
      P_AWADDR:  pv = {20'd0, awaddr};
      P_TDATA:   pv = tdata;
      P_TUSER:   pv = {31'd0, tuser};
      P_TLAST:   pv = {31'd0, tlast};
      P_BUSYCYC: pv = 32'(busy_cyc);
      P_AWCYC:   pv = 32'(awv_cyc);
      P_WCYC:    pv = 32'(wv_cyc);
      P_ARCNT:   pv = 32'(ar_cnt);
      P_BCNT:    pv = 32'(b_cnt);
      P_BEATS:   pv = 32'(beats);
      P_MISSB:   pv = {16'd0, missed_b};
      P_BUSYB:   pv = {31'd0, busy_b};
      default:   pv = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string pname(input int k);
    case (k)
      P_BUSY: pname = "busy";       P_AWV: pname = "awvalid";
      P_WV: pname = "wvalid";       P_ARV: pname = "arvalid";
      P_TV: pname = "tvalid";       P_BRDY: pname = "bready";
      P_RRDY: pname = "rready";     P_MISS: pname = "missed_count";
      P_ERR: pname = "err_count";   P_AWADDR: pname = "awaddr";
      P_TDATA: pname = "tdata";     P_TUSER: pname = "tuser";
      P_TLAST: pname = "tlast";     P_BUSYCYC: pname = "busy_cycles";
      P_AWCYC: pname = "awvalid_cycles";
      P_WCYC: pname = "wvalid_cycles";
      P_ARCNT: pname = "ar_count";  P_BCNT: pname = "b_count";
      P_BEATS: pname = "beat_count"; P_MISSB: pname = "timer_missed";
      P_BUSYB: pname = "timer_busy";
      default: pname = "unknown";
    endcase
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic extra(input string n, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h expected nothing at %0t", n, act, $time);
  endtask

  always @(negedge clk) begin
    probe_t pr;
    while (probe_q.size() > 0) begin
      pr = probe_q.pop_front();
      chk(pname(int'(pr.k)), 64'(pv(int'(pr.k))), 64'(pr.e));
    end
    if (rst) begin
      busy_cyc = 0; awv_cyc = 0; wv_cyc = 0;
      ar_cnt = 0; b_cnt = 0; beats = 0;
      prev_stall = 1'b0; prev_t = '0;
    end else begin
      if (busy) busy_cyc++;
      if (awvalid) awv_cyc++;
      if (wvalid) wv_cyc++;
      if (bvalid && bready) b_cnt++;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) extra("aw_extra", 64'(awaddr));
        else chk("aw_addr", 64'(awaddr), 64'(exp_aw.pop_front()));
      end
      if (wvalid && wready) begin
        chk("w_data", 64'(wdata), 64'd1);
        chk("w_strb", 64'(wstrb), 64'hF);
      end
      if (arvalid && arready) begin
        ar_cnt++;
        if (exp_ar.size() == 0) extra("ar_extra", 64'(araddr));
        else chk("ar_addr", 64'(araddr), 64'(exp_ar.pop_front()));
      end
      if (prev_stall) begin
        chk("t_hold", 64'({tdata, tuser, tlast}), 64'(prev_t));
        chk("ar_during_stall", 64'(arvalid), 64'd0);
      end
      prev_stall = tvalid && !tready;
      prev_t = {tdata, tuser, tlast};
      if (tvalid && tready) begin
        beats++;
        if (exp_q.size() == 0) extra("beat_extra", 64'(tdata));
        else chk("beat", 64'({tdata, tuser, tlast}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input int k, input logic [31:0] e);
    probe_t pr;
    pr.k = 8'(k);
    pr.e = e;
    probe_q.push_back(pr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic trig();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      if (!busy) done = 1'b1;
      else step(1);
    end
    if (!done) probe(P_BUSY, 32'd0);
  endtask

  task automatic push_snap(input int eidx);
    exp_aw.push_back(12'h000);
    for (int k = 0; k < 8; k++) begin
      exp_ar.push_back(12'(16 + 4 * k));
      exp_q.push_back({32'(16 + 4 * k), k == eidx, k == 7});
    end
  endtask

  initial begin
    do_reset();
    probe(P_BUSY, 0); probe(P_AWV, 0); probe(P_WV, 0);
    probe(P_ARV, 0); probe(P_TV, 0); probe(P_BRDY, 0);
    probe(P_RRDY, 0); probe(P_MISS, 0); probe(P_ERR, 0);
    probe(P_AWADDR, 0); probe(P_TDATA, 0); probe(P_TLAST, 0);
    step(1);

    // zero-wait snapshot: 8 beats, 26 busy cycles
    do_reset();
    push_snap(-1);
    trig();
    wait_idle(100);
    probe(P_BUSYCYC, 26); probe(P_ARCNT, 8); probe(P_BCNT, 1);
    probe(P_BEATS, 8); probe(P_ERR, 0); probe(P_MISS, 0);
    step(2);

    // awready delayed 3 cycles, wready immediate
    do_reset();
    aw_delay = 3;
    push_snap(-1);
    trig();
    wait_idle(100);
    probe(P_AWCYC, 4); probe(P_WCYC, 1); probe(P_BCNT, 1);
    probe(P_ARCNT, 8); probe(P_BEATS, 8);
    step(2);
    aw_delay = 0;

    // SLVERR on B: abort, no reads, no beats
    do_reset();
    cfg_bresp = 2'b10;
    exp_aw.push_back(12'h000);
    trig();
    wait_idle(50);
    probe(P_ARCNT, 0); probe(P_BEATS, 0); probe(P_ERR, 1);
    probe(P_BUSYCYC, 2);
    step(2);
    cfg_bresp = 2'b00;

    // SLVERR on third read only
    do_reset();
    rerr_idx = 2;
    push_snap(2);
    trig();
    wait_idle(100);
    probe(P_ERR, 1); probe(P_BEATS, 8); probe(P_BUSYCYC, 26);
    step(2);
    rerr_idx = -1;

    // sink stalls beat 2 for 10 cycles, three triggers while busy
    do_reset();
    stall_beat = 1;
    stall_len = 10;
    push_snap(-1);
    trig();
    step(3); trig();
    step(5); trig();
    step(5); trig();
    wait_idle(100);
    probe(P_MISS, 3); probe(P_BEATS, 8); probe(P_ARCNT, 8);
    probe(P_BUSYCYC, 36);
    step(2);
    stall_len = 0;

    // periodic instance with a stalled sink spans one expiry
    do_reset();
    tready_b = 1'b0;
    step(150);
    probe(P_MISSB, 0); probe(P_BUSYB, 1);
    step(100);
    tready_b = 1'b1;
    step(40);
    probe(P_MISSB, 1); probe(P_BUSYB, 0);
    step(1);

    // reset during the read phase with nonzero counters
    do_reset();
    rerr_idx = 0;
    push_snap(0);
    trig();
    step(3); trig();
    for (int k = 0; k < 20 && !arvalid; k++) step(1);
    probe(P_MISS, 1); probe(P_ERR, 1); probe(P_ARV, 1);
    step(1);
    rst = 1'b1;
    step(1);
    probe(P_AWV, 0); probe(P_WV, 0); probe(P_ARV, 0);
    probe(P_TV, 0); probe(P_RRDY, 0); probe(P_BUSY, 0);
    probe(P_MISS, 0); probe(P_ERR, 0); probe(P_TDATA, 0);
    step(1);
    rst = 1'b0;
    exp_q.delete();
    exp_ar.delete();
    exp_aw.delete();
    rerr_idx = -1;
    step(5);
    probe(P_BUSY, 0); probe(P_TV, 0);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
